// File: rtl/cpu_pkg.sv
// Opcode map, phase encoding and strobe bundle shared by the model CPU's sequencer, ALU and control generator.
package cpu_pkg;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_MOVI = 4'h1;
  localparam logic [3:0] OPC_IN   = 4'h2;
  localparam logic [3:0] OPC_OUT  = 4'h3;
  localparam logic [3:0] OPC_JMP  = 4'h4;
  localparam logic [3:0] OPC_JG   = 4'h5;
  localparam logic [3:0] OPC_HALT = 4'h6;
  localparam logic [3:0] OPC_SUB  = 4'h8;
  localparam logic [3:0] OPC_ADD  = 4'h9;
  localparam logic [3:0] OPC_MOVA = 4'hC;
  localparam logic [3:0] OPC_MOVB = 4'hD;
  localparam logic [3:0] OPC_MOVC = 4'hE;
  localparam logic [3:0] OPC_MOVD = 4'hF;

  localparam logic PH_FETCH = 1'b0;
  localparam logic PH_EXEC  = 1'b1;

  typedef struct packed {
    logic mova;
    logic movb;
    logic movc;
    logic movd;
    logic movi;
    logic add;
    logic sub;
    logic in1;
    logic out1;
    logic jmp;
    logic jg;
    logic halt;
  } strobe_t;

  // Opcodes 7, A and B have no instruction assigned; they execute as NOP.
  function automatic logic opc_undefined(input logic [3:0] opc);
    return (opc == 4'h7) || (opc == 4'hA) || (opc == 4'hB);
  endfunction

endpackage

// File: rtl/instr_seq_decode_step_sync.sv
// Single-step button conditioning: SYNC_STAGES-deep synchroniser followed by a rising-edge detector.
// step_pulse is high for one cycle, SYNC_STAGES cycles after the button is first sampled high.
module step_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic step_btn,
  output logic step_pulse
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   btn_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff  <= '0;
      btn_last <= 1'b0;
    end else begin
      sync_ff  <= {sync_ff[SYNC_STAGES-2:0], step_btn};
      btn_last <= sync_ff[SYNC_STAGES-1];
    end
  end

  // A held button produces a single pulse: only the 0->1 transition counts.
  assign step_pulse = sync_ff[SYNC_STAGES-1] & ~btn_last;

endmodule

// File: rtl/instr_seq_decode.sv
// Fetch/execute sequencer and instruction decoder: IR, phase bit sm, G flag and one-hot strobes.
// Strobes are decoded combinationally from registered ir/sm, so they are valid in the execute cycle itself.
module instr_seq_decode
  import cpu_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IR_RST      = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ram_dout,
  input  logic       ir_ld,
  input  logic       sm_en,
  input  logic       gf_en,
  input  logic       alu_gt,
  input  logic       step_mode,
  input  logic       step_btn,
  output logic [7:0] ir,
  output logic       sm,
  output logic       g,
  output logic       mova,
  output logic       movb,
  output logic       movc,
  output logic       movd,
  output logic       movi,
  output logic       add,
  output logic       sub,
  output logic       in1,
  output logic       out1,
  output logic       jmp,
  output logic       jg,
  output logic       halt,
  output logic       halted,
  output logic       illegal
);

  logic       step_pulse;
  logic       adv;
  logic [3:0] opc;
  strobe_t    dec;

  step_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_step_sync (
    .clk        (clk),
    .rst        (rst),
    .step_btn   (step_btn),
    .step_pulse (step_pulse)
  );

  // In step mode a pulse is only consumed in the cycle it appears; otherwise it is dropped.
  assign adv = sm_en & (~step_mode | step_pulse);

  always_ff @(posedge clk) begin
    if (rst) begin
      ir <= IR_RST;
      sm <= PH_FETCH;
      g  <= 1'b0;
    end else begin
      if (ir_ld && adv) begin
        ir <= ram_dout;
      end
      if (adv) begin
        sm <= ~sm;
      end
      if (gf_en) begin
        g <= alu_gt;
      end
    end
  end

  assign opc = ir[7:4];

  always_comb begin
    dec = '0;
    if (sm == PH_EXEC) begin
      case (opc)
        OPC_MOVI: dec.movi = 1'b1;
        OPC_IN:   dec.in1  = 1'b1;
        OPC_OUT:  dec.out1 = 1'b1;
        OPC_JMP:  dec.jmp  = 1'b1;
        OPC_JG:   dec.jg   = 1'b1;
        OPC_HALT: dec.halt = 1'b1;
        OPC_SUB:  dec.sub  = 1'b1;
        OPC_ADD:  dec.add  = 1'b1;
        OPC_MOVA: dec.mova = 1'b1;
        OPC_MOVB: dec.movb = 1'b1;
        OPC_MOVC: dec.movc = 1'b1;
        OPC_MOVD: dec.movd = 1'b1;
        default:  dec      = '0;
      endcase
    end
  end

  assign mova    = dec.mova;
  assign movb    = dec.movb;
  assign movc    = dec.movc;
  assign movd    = dec.movd;
  assign movi    = dec.movi;
  assign add     = dec.add;
  assign sub     = dec.sub;
  assign in1     = dec.in1;
  assign out1    = dec.out1;
  assign jmp     = dec.jmp;
  assign jg      = dec.jg;
  assign halt    = dec.halt;
  assign halted  = (sm == PH_EXEC) && (opc == OPC_HALT);
  assign illegal = (sm == PH_EXEC) && opc_undefined(opc);

endmodule

// File: tb/tb_instr_seq_decode.sv
// Bench for instr_seq_decode: directed scenarios then random traffic, scored against a cycle model.
module tb_instr_seq_decode;

  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic [7:0]  ir;
    logic        sm;
    logic        g;
    logic [11:0] strb;
    logic        halted;
    logic        illegal;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] ram_dout;
  logic       ir_ld, sm_en, gf_en, alu_gt, step_mode, step_btn;
  logic [7:0] ir;
  logic       sm, g;
  logic       mova, movb, movc, movd, movi, add, sub, in1, out1, jmp, jg, halt;
  logic       halted, illegal;
  logic [11:0] dut_strb;

  int checks   = 0;
  int failures = 0;

  exp_t sb[$];
  exp_t mon_e;

  // reference state
  logic [7:0] m_ir;
  logic       m_sm;
  logic       m_g;
  bit         hq[$];
  // bit position in {mova,movb,movc,movd,movi,add,sub,in1,out1,jmp,jg,halt} per opcode, -1 = none
  int pos_of [16] = '{-1, 7, 4, 3, 2, 1, 0, -1, 5, 6, -1, -1, 11, 10, 9, 8};

  instr_seq_decode #(
    .SYNC_STAGES (SYNC_STAGES),
    .IR_RST      (8'h00)
  ) dut (
    .clk(clk), .rst(rst), .ram_dout(ram_dout), .ir_ld(ir_ld), .sm_en(sm_en),
    .gf_en(gf_en), .alu_gt(alu_gt), .step_mode(step_mode), .step_btn(step_btn),
    .ir(ir), .sm(sm), .g(g),
    .mova(mova), .movb(movb), .movc(movc), .movd(movd), .movi(movi), .add(add),
    .sub(sub), .in1(in1), .out1(out1), .jmp(jmp), .jg(jg), .halt(halt),
    .halted(halted), .illegal(illegal)
  );

  assign dut_strb = {mova, movb, movc, movd, movi, add, sub, in1, out1, jmp, jg, halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a state; compare it against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("ir",      {4'h0, ir},       {4'h0, mon_e.ir});
      chk("sm",      {11'h0, sm},      {11'h0, mon_e.sm});
      chk("g",       {11'h0, g},       {11'h0, mon_e.g});
      chk("strobes", dut_strb,         mon_e.strb);
      chk("halted",  {11'h0, halted},  {11'h0, mon_e.halted});
      chk("illegal", {11'h0, illegal}, {11'h0, mon_e.illegal});
      chk("onehot",  {11'h0, ($countones(dut_strb) <= 1)}, 12'h001);
    end
  end

  // One clock edge of the model, using the inputs currently applied.
  task automatic model_step();
    bit pulse;
    bit adv;
    if (rst) begin
      m_ir = 8'h00;
      m_sm = 1'b0;
      m_g  = 1'b0;
      hq   = {};
      for (int i = 0; i <= SYNC_STAGES; i++) hq.push_back(1'b0);
    end else begin
      // rising edge of the button as seen SYNC_STAGES samples ago
      pulse = hq[SYNC_STAGES - 1] && !hq[SYNC_STAGES - 2 - (SYNC_STAGES - 2)];
      pulse = hq[hq.size() - SYNC_STAGES] && !hq[hq.size() - SYNC_STAGES - 1];
      adv   = sm_en && (!step_mode || pulse);
      if (ir_ld && adv) m_ir = ram_dout;
      if (adv) m_sm = !m_sm;
      if (gf_en) m_g = alu_gt;
      hq.push_back(step_btn);
      void'(hq.pop_front());
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   op;
    op        = int'(m_ir[7:4]);
    e.ir      = m_ir;
    e.sm      = m_sm;
    e.g       = m_g;
    e.strb    = '0;
    if (m_sm && pos_of[op] >= 0) e.strb[pos_of[op]] = 1'b1;
    e.halted  = m_sm && (op == 6);
    e.illegal = m_sm && (op == 7 || op == 10 || op == 11);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    sb.push_back(model_out());
    #1;
  endtask

  // Bring the next instruction byte into execute (normal run mode assumed).
  task automatic fetch_exec(input logic [7:0] b);
    sm_en = 1'b1;
    gf_en = 1'b0;
    if (m_sm) begin
      ir_ld    = 1'b0;
      ram_dout = 8'h00;
      tick();
    end
    ir_ld    = 1'b1;
    ram_dout = b;
    tick();
    ir_ld    = 1'b0;
  endtask

  initial begin
    m_ir = 8'h00; m_sm = 1'b0; m_g = 1'b0;
    for (int i = 0; i <= SYNC_STAGES; i++) hq.push_back(1'b0);
    rst = 1'b1; ram_dout = 8'h96; ir_ld = 1'b1; sm_en = 1'b1; gf_en = 1'b0;
    alu_gt = 1'b0; step_mode = 1'b0; step_btn = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // ADD through a full fetch/execute/fetch
    fetch_exec(8'h96);
    tick();

    // SUB sets G, G holds when gf_en drops
    fetch_exec(8'h84);
    gf_en = 1'b1; alu_gt = 1'b1;
    tick();
    gf_en = 1'b0; alu_gt = 1'b0; ir_ld = 1'b1; ram_dout = 8'h00;
    tick(); tick();

    // HALT with sm_en driven as the control generator would, then reset out of it
    fetch_exec(8'h60);
    for (int i = 0; i < 25; i++) begin
      sm_en = !(m_sm && m_ir[7:4] == 4'h6);
      step_btn = i[2];
      tick();
    end
    rst = 1'b1; step_btn = 1'b0;
    tick();
    rst = 1'b0; sm_en = 1'b1;

    // single step: held button yields one advance
    step_mode = 1'b1; ir_ld = 1'b1; ram_dout = 8'h1B;
    step_btn = 1'b1;
    repeat (10) tick();
    step_btn = 1'b0;
    repeat (4) tick();
    step_btn = 1'b1;
    repeat (5) tick();
    step_btn = 1'b0;
    repeat (4) tick();
    step_mode = 1'b0;

    // undefined opcode then MOVA
    fetch_exec(8'hA5);
    tick();
    fetch_exec(8'hC4);
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      ram_dout = 8'($urandom);
      ir_ld    = m_sm ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0);
      if (m_sm && m_ir[7:4] == 4'h6) sm_en = ($urandom_range(0, 15) == 0);
      else                            sm_en = ($urandom_range(0, 7) != 0);
      gf_en    = 1'($urandom_range(0, 1));
      alu_gt   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) step_mode = ~step_mode;
      if ($urandom_range(0, 3) == 0)  step_btn  = ~step_btn;
      tick();
    end
    rst = 1'b0;

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation_time=%0t limit=500000", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
